instruction_fetch: RTL and testbench

Sits directly downstream of the program counter and upstream of decode. Reads the 8-bit instruction memory one byte per cycle at the PC's current address. Assembles 4 bytes into a 32-bit instruction word and presents it to decode with a valid/ready handshake. Generates the PC's update_lsbs and update_msbs pulses, and yields PC control to decode's jump/branch on a redirect.

---
 rtl/instruction_fetch_pkg.sv | 15 +
 rtl/instruction_fetch.sv | 97 +++++++++
 tb/tb_instruction_fetch.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared constants for the byte-serial instruction fetch stage.
package instruction_fetch_pkg;

  localparam int BYTE_W          = 8;
  localparam int INSTR_W         = 32;
  localparam int CNT_W           = 16;
  localparam int BYTES_PER_INSTR = INSTR_W / BYTE_W;

  localparam logic FETCH = 1'b0;
  localparam logic HOLD  = 1'b1;

  // Big-endian lane placement: lane 0 (lsbs=0) lands in the top byte.
  localparam int LANE_LSB [BYTES_PER_INSTR] = '{24, 16, 8, 0};

endpackage

// File: rtl/instruction_fetch.sv
// Byte-serial instruction fetch: assembles four memory bytes into one word,
// hands it to decode over valid/ready and steps the PC with update pulses.
//
// state | meaning
// FETCH | capturing byte byte_cnt (0..3) from memory at the PC
// HOLD  | complete instruction presented to decode, waiting for instr_ready
module instruction_fetch
  import instruction_fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [BYTE_W-1:0]  mem_rdata,
  input  logic [1:0]         pc_lsbs,
  output logic               update_lsbs,
  output logic               update_msbs,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect,
  output logic [CNT_W-1:0]   instr_count,
  output logic               align_err
);

  logic       state;
  logic [1:0] byte_cnt;
  logic       capture;
  logic       last_byte;
  logic       accept;

  assign capture   = !rst && (state == FETCH) && enable;
  assign last_byte = (byte_cnt == 2'(BYTES_PER_INSTR - 1));
  assign accept    = !rst && (state == HOLD) && instr_ready;

  // PC's update_msbs outranks jump/branch, so it must stay low on a redirect.
  assign update_lsbs = capture && !last_byte;
  assign update_msbs = accept && !redirect;
  assign instr_valid = (state == HOLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FETCH;
      byte_cnt <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (enable) begin
            if (last_byte) begin
              state    <= HOLD;
              byte_cnt <= '0;
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end
        HOLD: begin
          if (instr_ready) begin
            state    <= FETCH;
            byte_cnt <= '0;
          end
        end
        default: begin
          state    <= FETCH;
          byte_cnt <= '0;
        end
      endcase
    end
  end

  // Lanes are overwritten progressively; the previous word is never cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr <= '0;
    end else if (capture) begin
      for (int i = 0; i < BYTES_PER_INSTR; i++) begin
        if (byte_cnt == 2'(i)) begin
          instr[LANE_LSB[i] +: BYTE_W] <= mem_rdata;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_count <= '0;
      align_err   <= 1'b0;
    end else begin
      if (accept) begin
        instr_count <= instr_count + 1'b1;
      end
      if (capture && (pc_lsbs != byte_cnt)) begin
        align_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a small PC and memory model.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [7:0]  mem_rdata;
  logic [1:0]  pc_lsbs;
  logic        update_lsbs;
  logic        update_msbs;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [15:0] instr_count;
  logic        align_err;

  logic [7:0]  mem [0:255];
  logic [7:0]  pc;
  logic        jump;
  logic [5:0]  jump_target;
  logic        pc_force;
  logic [7:0]  pc_force_val;

  int checks = 0;
  int errors = 0;

  instruction_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .mem_rdata   (mem_rdata),
    .pc_lsbs     (pc_lsbs),
    .update_lsbs (update_lsbs),
    .update_msbs (update_msbs),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .instr_count (instr_count),
    .align_err   (align_err)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[pc];
  assign pc_lsbs   = pc[1:0];

  // PC model: update_msbs has priority over jump, jump over update_lsbs.
  always @(posedge clk or posedge rst) begin
    if (rst)              pc <= 8'h00;
    else if (pc_force)    pc <= pc_force_val;
    else if (update_msbs) pc <= {pc[7:2] + 6'd1, 2'b00};
    else if (jump)        pc <= {jump_target, 2'b00};
    else if (update_lsbs) pc <= {pc[7:2], pc[1:0] + 2'd1};
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Fetches four bytes checking the update_lsbs pattern 1,1,1,0.
  task automatic fetch_word(input string tag);
    logic exp_l;
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_l = (i < 3);
      checks++;
      if (update_lsbs !== exp_l || update_msbs !== 1'b0 || instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s_fetch byte %0d: lsbs=%b msbs=%b valid=%b expected lsbs=%b msbs=0 valid=0",
                 tag, i, update_lsbs, update_msbs, instr_valid, exp_l);
      end
      tick();
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; enable = 1'b1; instr_ready = 1'b0; redirect = 1'b0;
    jump = 1'b0; jump_target = '0; pc_force = 1'b0; pc_force_val = '0;
    tick(); tick();
    checks++;
    if (instr !== 32'h0 || instr_valid !== 1'b0 || instr_count !== 16'h0 ||
        align_err !== 1'b0 || update_lsbs !== 1'b0 || update_msbs !== 1'b0) begin
      errors++;
      $display("FAIL reset: instr=%h valid=%b cnt=%h aerr=%b lsbs=%b msbs=%b expected all zero",
               instr, instr_valid, instr_count, align_err, update_lsbs, update_msbs);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    instr_ready = 1'b1;
    fetch_word("basic");
    #1;
    checks++;
    if (instr !== 32'h12345678 || instr_valid !== 1'b1 || update_msbs !== 1'b1 || update_lsbs !== 1'b0) begin
      errors++;
      $display("FAIL basic_hold: instr=%h valid=%b msbs=%b lsbs=%b expected 12345678 1 1 0",
               instr, instr_valid, update_msbs, update_lsbs);
    end
    tick();
    checks++;
    if (pc !== 8'h04 || instr_count !== 16'd1 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_accept: pc=%h cnt=%0d valid=%b expected 04 1 0", pc, instr_count, instr_valid);
    end
  endtask

  task automatic test_hold_stall;
    instr_ready = 1'b0;
    fetch_word("stall");
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (instr !== 32'hA1B2C3D4 || instr_valid !== 1'b1 || update_lsbs !== 1'b0 ||
          update_msbs !== 1'b0 || pc !== 8'h07) begin
        errors++;
        $display("FAIL stall_hold cycle %0d: instr=%h valid=%b lsbs=%b msbs=%b pc=%h expected a1b2c3d4 1 0 0 07",
                 i, instr, instr_valid, update_lsbs, update_msbs, pc);
      end
      tick();
    end
    instr_ready = 1'b1;
    #1;
    checks++;
    if (update_msbs !== 1'b1 || update_lsbs !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: msbs=%b lsbs=%b expected 1 0", update_msbs, update_lsbs);
    end
    tick();
    checks++;
    if (instr_count !== 16'd2 || pc !== 8'h08) begin
      errors++;
      $display("FAIL stall_accept: cnt=%0d pc=%h expected 2 08", instr_count, pc);
    end
  endtask

  task automatic test_redirect;
    instr_ready = 1'b0;
    fetch_word("redir");
    instr_ready = 1'b1; redirect = 1'b1; jump = 1'b1; jump_target = 6'd6;
    #1;
    checks++;
    if (update_msbs !== 1'b0 || update_lsbs !== 1'b0 || instr !== 32'hCAFEBABE) begin
      errors++;
      $display("FAIL redirect_cycle: msbs=%b lsbs=%b instr=%h expected 0 0 cafebabe",
               update_msbs, update_lsbs, instr);
    end
    tick();
    redirect = 1'b0; jump = 1'b0;
    checks++;
    if (pc !== 8'h18 || instr_count !== 16'd3 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL redirect_target: pc=%h cnt=%0d valid=%b expected 18 3 0", pc, instr_count, instr_valid);
    end
    fetch_word("after_redir");
    #1;
    checks++;
    if (instr !== 32'hDEADBEEF || instr_valid !== 1'b1 || update_msbs !== 1'b1) begin
      errors++;
      $display("FAIL redirect_fetch: instr=%h valid=%b msbs=%b expected deadbeef 1 1",
               instr, instr_valid, update_msbs);
    end
    tick();
    checks++;
    if (pc !== 8'h1C || instr_count !== 16'd4) begin
      errors++;
      $display("FAIL redirect_accept: pc=%h cnt=%0d expected 1c 4", pc, instr_count);
    end
  endtask

  task automatic test_enable_pause;
    tick(); tick();
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (update_lsbs !== 1'b0 || pc !== 8'h1E || instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL pause cycle %0d: lsbs=%b pc=%h valid=%b expected 0 1e 0", i, update_lsbs, pc, instr_valid);
      end
      tick();
    end
    enable = 1'b1;
    #1;
    checks++;
    if (update_lsbs !== 1'b1) begin
      errors++;
      $display("FAIL pause_resume: lsbs=%b expected 1", update_lsbs);
    end
    tick();
    #1;
    checks++;
    if (update_lsbs !== 1'b0 || pc !== 8'h1F) begin
      errors++;
      $display("FAIL pause_last: lsbs=%b pc=%h expected 0 1f", update_lsbs, pc);
    end
    tick();
    checks++;
    if (instr !== 32'h01020304 || instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL pause_word: instr=%h valid=%b expected 01020304 1", instr, instr_valid);
    end
    tick();
    checks++;
    if (instr_count !== 16'd5 || pc !== 8'h20) begin
      errors++;
      $display("FAIL pause_accept: cnt=%0d pc=%h expected 5 20", instr_count, pc);
    end
  endtask

  task automatic test_align;
    #1;
    checks++;
    if (align_err !== 1'b0) begin
      errors++;
      $display("FAIL align_clean: align_err=%b expected 0", align_err);
    end
    pc_force = 1'b1; pc_force_val = 8'h22;
    tick();
    pc_force = 1'b0;
    checks++;
    if (align_err !== 1'b0 || pc_lsbs !== 2'd2) begin
      errors++;
      $display("FAIL align_before: align_err=%b pc_lsbs=%0d expected 0 2", align_err, pc_lsbs);
    end
    tick();
    checks++;
    if (align_err !== 1'b1) begin
      errors++;
      $display("FAIL align_set: align_err=%b expected 1", align_err);
    end
    tick(); tick();
    checks++;
    if (instr !== 32'h11334411 || instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL align_word: instr=%h valid=%b expected 11334411 1", instr, instr_valid);
    end
    tick();
    fetch_word("align_next");
    checks++;
    if (instr !== 32'h55667788 || align_err !== 1'b1 || pc !== 8'h27) begin
      errors++;
      $display("FAIL align_sticky: instr=%h align_err=%b pc=%h expected 55667788 1 27", instr, align_err, pc);
    end
    tick();
    checks++;
    if (instr_count !== 16'd7 || align_err !== 1'b1) begin
      errors++;
      $display("FAIL align_accept: cnt=%0d align_err=%b expected 7 1", instr_count, align_err);
    end
  endtask

  task automatic test_reset_mid;
    tick(); tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (instr !== 32'h0 || instr_valid !== 1'b0 || instr_count !== 16'h0 ||
        align_err !== 1'b0 || update_lsbs !== 1'b0 || update_msbs !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: instr=%h valid=%b cnt=%h aerr=%b lsbs=%b msbs=%b expected all zero",
               instr, instr_valid, instr_count, align_err, update_lsbs, update_msbs);
    end
    tick();
    rst = 1'b0;
    fetch_word("restart");
    checks++;
    if (instr !== 32'h12345678 || instr_valid !== 1'b1 || align_err !== 1'b0) begin
      errors++;
      $display("FAIL restart_word: instr=%h valid=%b aerr=%b expected 12345678 1 0", instr, instr_valid, align_err);
    end
    tick();
    checks++;
    if (instr_count !== 16'd1 || pc !== 8'h04) begin
      errors++;
      $display("FAIL restart_accept: cnt=%0d pc=%h expected 1 04", instr_count, pc);
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    {mem[8'h00], mem[8'h01], mem[8'h02], mem[8'h03]} = 32'h12345678;
    {mem[8'h04], mem[8'h05], mem[8'h06], mem[8'h07]} = 32'hA1B2C3D4;
    {mem[8'h08], mem[8'h09], mem[8'h0A], mem[8'h0B]} = 32'hCAFEBABE;
    {mem[8'h18], mem[8'h19], mem[8'h1A], mem[8'h1B]} = 32'hDEADBEEF;
    {mem[8'h1C], mem[8'h1D], mem[8'h1E], mem[8'h1F]} = 32'h01020304;
    {mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23]} = 32'h11223344;
    {mem[8'h24], mem[8'h25], mem[8'h26], mem[8'h27]} = 32'h55667788;
    {mem[8'h28], mem[8'h29], mem[8'h2A], mem[8'h2B]} = 32'h9ABCDEF0;

    test_reset();
    test_basic();
    test_hold_stall();
    test_redirect();
    test_enable_pause();
    test_align();
    test_reset_mid();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
